// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, sign fix-up in a final cycle.
module mul_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [XLEN-1:0] MD_Src_A,
  input  logic [XLEN-1:0] MD_Src_B,
  input  logic [2:0]      MDControl,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MDResult
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [2:0]        op_reg, op_next;
  logic              neg_reg, neg_next;
  logic [XLEN:0]     acc_reg, acc_next;    // product high half / partial remainder
  logic [XLEN-1:0]   lo_reg, lo_next;      // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]   opnd_reg, opnd_next;  // multiplicand / divisor magnitude
  logic [XLEN-1:0]   result_reg, result_next;

  // Operand decode at acceptance
  logic              in_div, in_rem, sign_a, sign_b, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;

  always_comb begin
    in_div   = MDControl[2];
    in_rem   = MDControl[2] & MDControl[1];
    sign_a   = MD_Src_A[XLEN-1] & ((MDControl == OP_MULH) || (MDControl == OP_MULHSU) ||
                                   (MDControl == OP_DIV)  || (MDControl == OP_REM));
    sign_b   = MD_Src_B[XLEN-1] & ((MDControl == OP_MULH) || (MDControl == OP_DIV) ||
                                   (MDControl == OP_REM));
    mag_a    = sign_a ? (~MD_Src_A + 1'b1) : MD_Src_A;
    mag_b    = sign_b ? (~MD_Src_B + 1'b1) : MD_Src_B;
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_in   = in_rem ? sign_a : (sign_a ^ sign_b);
    div_zero = in_div && (MD_Src_B == '0);
    div_ovf  = ((MDControl == OP_DIV) || (MDControl == OP_REM)) &&
               (MD_Src_A == {1'b1, {(XLEN-1){1'b0}}}) && (MD_Src_B == '1);
  end

  // Per-iteration datapath
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[XLEN-1:0]} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[XLEN-1:0], lo_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_diff  = div_shift - {1'b0, opnd_reg};
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    product  = {acc_reg[XLEN-1:0], lo_reg};
    prod_fix = neg_reg ? (~product + 1'b1) : product;
    quo_fix  = neg_reg ? (~lo_reg + 1'b1) : lo_reg;
    rem_fix  = neg_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
    case (op_reg)
      OP_MUL:                   fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:           fix_result = quo_fix;
      default:                  fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    neg_next    = neg_reg;
    acc_next    = acc_reg;
    lo_next     = lo_reg;
    opnd_next   = opnd_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (Start) begin
          op_next    = MDControl;
          neg_next   = neg_in;
          acc_next   = '0;
          lo_next    = in_div ? mag_a : mag_b;
          opnd_next  = in_div ? mag_b : mag_a;
          count_next = '0;
          if (div_zero) begin
            result_next = in_rem ? MD_Src_A : '1;
            state_next  = DONE;
          end else if (div_ovf) begin
            result_next = in_rem ? '0 : MD_Src_A;
            state_next  = DONE;
          end else begin
            state_next  = CALC;
          end
        end
      end
      CALC: begin
        if (op_reg[2]) begin
          acc_next = div_ge ? div_diff : div_shift;
          lo_next  = {lo_reg[XLEN-2:0], div_ge};
        end else begin
          acc_next = {1'b0, mul_sum[XLEN:1]};
          lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(ITER - 1)) state_next = FIX;
      end
      FIX: begin
        result_next = fix_result;
        state_next  = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      neg_reg    <= neg_next;
      acc_reg    <= acc_next;
      lo_reg     <= lo_next;
      opnd_reg   <= opnd_next;
      result_reg <= result_next;
    end
  end

  assign Busy     = (state_reg == CALC) || (state_reg == FIX);
  assign Done     = (state_reg == DONE);
  assign MDResult = result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results are queued at issue
// time from a 64-bit arithmetic model and popped by a monitor on each Done.
`timescale 1ns/1ps
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] MD_Src_A = '0;
  logic [31:0] MD_Src_B = '0;
  logic [2:0]  MDControl = '0;
  logic        Busy, Done;
  logic [31:0] MDResult;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .MD_Src_A(MD_Src_A), .MD_Src_B(MD_Src_B), .MDControl(MDControl),
    .Busy(Busy), .Done(Done), .MDResult(MDResult)
  );

  always #5 CLK = ~CLK;

  // Reference model: RISC-V M semantics using wide signed/unsigned arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sp = sa * sb;   return sp[31:0];  end
      3'd1: begin sp = sa * sb;   return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub;   return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; sp = sa / sb; return sp[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_done: got Done with MDResult=%08h, required no Done", MDResult);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (MDResult !== e) begin
          fails++;
          $display("FAIL result_%s: got %08h, required %08h", n, MDResult, e);
        end else
          $display("[TB] %s -> %08h ok", n, MDResult);
      end
    end
  end

  // Issue one operation; called away from the clock edge. With wait_done the
  // task returns at the negedge of the Done cycle; inputs are scrambled and
  // Start toggled while the unit is busy, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit wait_done);
    bit  special, busy_bad;
    int  done_n, lat;
    string nm;
    special = is_special(op, a, b);
    lat     = special ? 1 : 34;
    nm      = $sformatf("op%0d_%08h_%08h", op, a, b);
    exp_q.push_back(ref_model(op, a, b));
    name_q.push_back(nm);
    Start = 1'b1; MD_Src_A = a; MD_Src_B = b; MDControl = op;
    @(posedge CLK); #1;
    Start = 1'b0; MD_Src_A = $urandom; MD_Src_B = $urandom; MDControl = 3'($urandom);
    if (!wait_done) return;
    busy_bad = 1'b0;
    done_n   = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (Busy !== (!special && n < 34)) busy_bad = 1'b1;
      if (Done === 1'b1) begin done_n = n; break; end
      if (n <= 30) begin
        Start = 1'($urandom_range(0, 1));
        MD_Src_A = $urandom; MD_Src_B = $urandom; MDControl = 3'($urandom);
      end else
        Start = 1'b0;
    end
    Start = 1'b0;
    tests++;
    if (done_n != lat) begin
      fails++;
      $display("FAIL latency_%s: got Done at cycle %0d, required %0d", nm, done_n, lat);
    end
    tests++;
    if (busy_bad) begin
      fails++;
      $display("FAIL busy_%s: Busy profile wrong, required high only on cycles 1..%0d", nm, special ? 0 : 33);
    end
  endtask

  task automatic gap_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    run_op(op, a, b, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious;
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    tests += 3;
    if (Busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b, required 0", Busy); end
    if (Done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b, required 0", Done); end
    if (MDResult !== 32'h0)   begin fails++; $display("FAIL reset_result: got %08h, required 00000000", MDResult); end

    // Directed cases
    gap_op(3'd0, 32'd7,        32'hFFFFFFFD);
    gap_op(3'd1, 32'h80000000, 32'h80000000);
    gap_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    gap_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    gap_op(3'd4, 32'hFFFFFFF9, 32'd2);
    gap_op(3'd6, 32'hFFFFFFF9, 32'd2);
    gap_op(3'd5, 32'd100,      32'd7);
    gap_op(3'd7, 32'd100,      32'd7);
    gap_op(3'd5, 32'h1234,     32'h0);
    gap_op(3'd6, 32'h1234,     32'h0);
    gap_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
    gap_op(3'd6, 32'h80000000, 32'hFFFFFFFF);

    // Back-to-back: new Start in the Done cycle
    gap_op(3'd0, 32'h0001_0003, 32'h0000_0101);
    run_op(3'd5, 32'hDEADBEEF,  32'd12345, 1'b1);
    run_op(3'd7, 32'h55,        32'h0, 1'b1);
    run_op(3'd4, 32'h80000000,  32'hFFFFFFFF, 1'b1);
    run_op(3'd1, 32'h7FFFFFFF,  32'h80000001, 1'b1);

    // Reset during CALC cycle 10
    gap_op(3'd4, 32'h00BADBAD, 32'd3);
    @(posedge CLK); #1;
    run_op(3'd4, 32'h12345678, 32'd9, 1'b0);
    repeat (9) @(posedge CLK);
    #1 Reset = 1'b1;
    @(posedge CLK); #1;
    tests += 3;
    if (Busy !== 1'b0)      begin fails++; $display("FAIL midreset_busy: got %b, required 0", Busy); end
    if (Done !== 1'b0)      begin fails++; $display("FAIL midreset_done: got %b, required 0", Done); end
    if (MDResult !== 32'h0) begin fails++; $display("FAIL midreset_result: got %08h, required 00000000", MDResult); end
    void'(exp_q.pop_back());
    void'(name_q.pop_back());
    Reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done === 1'b1) spurious++;
    end
    tests++;
    if (spurious != 0) begin fails++; $display("FAIL midreset_nodone: got %0d Done pulses, required 0", spurious); end

    // Randomized operations, some with corner operands and back-to-back issue
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       a = 32'h80000000;
        1:       a = 32'h0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) run_op(op, a, b, 1'b1);
      else                           gap_op(op, a, b);
    end

    repeat (4) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL outstanding: got %0d results never delivered, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
